barrel_shifter_arbiter: RTL and testbench

Shares one 8-bit combinational rotator (`barrel_shifter`) between two independent requesters using valid/ready handshakes. Requests are arbitrated round-robin or by fixed priority, rotated, and captured in a one-deep output register tagged with the requester ID. The block sits between client logic and the rotator, so the rotator never has to be duplicated per client.

---
 rtl/barrel_shifter_arbiter_pkg.sv | 14 +
 rtl/barrel_shifter_arbiter_barrel_shifter.sv | 20 ++
 rtl/barrel_shifter_arbiter.sv | 103 ++++++++++
 tb/tb_barrel_shifter_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_arbiter_pkg.sv
// Shared types and widths for the two-client rotator arbiter.
// State encoding and data, rotate and ID widths.
package barrel_shifter_arbiter_pkg;

    localparam int DW  = 8;
    localparam int KW  = 3;
    localparam int IDW = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/barrel_shifter_arbiter_barrel_shifter.sv
// Combinational 8-bit left rotator built as three log2 stages.
// Each stage rotates by 1, 2 or 4 when its bit of k is set.
module barrel_shifter
    import barrel_shifter_arbiter_pkg::*;
(
    output logic [DW-1:0] o_Y,
    input  logic [DW-1:0] i_A,
    input  logic [KW-1:0] i_k
);

    logic [DW-1:0] s1;
    logic [DW-1:0] s2;

    always_comb begin
        s1  = i_k[0] ? {i_A[DW-2:0], i_A[DW-1]}        : i_A;
        s2  = i_k[1] ? {s1[DW-3:0], s1[DW-1:DW-2]}     : s1;
        o_Y = i_k[2] ? {s2[DW-5:0], s2[DW-1:DW-4]}     : s2;
    end

endmodule

// File: rtl/barrel_shifter_arbiter.sv
// Two requesters share one rotator through a round-robin or fixed
// priority arbiter feeding a one-deep, ID-tagged result register.
module barrel_shifter_arbiter
    import barrel_shifter_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_req0_valid,
    output logic           o_req0_ready,
    input  logic [DW-1:0]  i_req0_A,
    input  logic [KW-1:0]  i_req0_k,
    input  logic           i_req1_valid,
    output logic           o_req1_ready,
    input  logic [DW-1:0]  i_req1_A,
    input  logic [KW-1:0]  i_req1_k,
    output logic           o_rsp_valid,
    input  logic           i_rsp_ready,
    output logic [DW-1:0]  o_rsp_Y,
    output logic [IDW-1:0] o_rsp_id
);

    state_t         state;
    state_t         state_nxt;
    logic           can_load;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] last_gnt;
    logic [DW-1:0]  sel_a;
    logic [KW-1:0]  sel_k;
    logic [DW-1:0]  rot_y;
    logic [DW-1:0]  rsp_y;
    logic [IDW-1:0] rsp_id;

    // Readys are held low while reset is asserted.
    always_comb begin
        can_load = (state == ST_EMPTY) || i_rsp_ready;
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        if (can_load && i_rstn) begin
            unique case (1'b1)
                (i_req0_valid && i_req1_valid): begin
                    gnt_vld = 1'b1;
                    gnt_id  = RR_EN ? ~last_gnt : '0;
                end
                (i_req0_valid && !i_req1_valid): begin
                    gnt_vld = 1'b1;
                    gnt_id  = '0;
                end
                (!i_req0_valid && i_req1_valid): begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_id  = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (gnt_vld) begin
            state_nxt = ST_FULL;
        end else if (state == ST_FULL && i_rsp_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    assign sel_a = (gnt_id == 1'b1) ? i_req1_A : i_req0_A;
    assign sel_k = (gnt_id == 1'b1) ? i_req1_k : i_req0_k;

    barrel_shifter u_rot (
        .o_Y (rot_y),
        .i_A (sel_a),
        .i_k (sel_k)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_EMPTY;
            rsp_y    <= '0;
            rsp_id   <= '0;
            last_gnt <= '1;
        end else begin
            state <= state_nxt;
            if (gnt_vld) begin
                rsp_y    <= rot_y;
                rsp_id   <= gnt_id;
                last_gnt <= gnt_id;
            end
        end
    end

    assign o_req0_ready = gnt_vld && (gnt_id == 1'b0);
    assign o_req1_ready = gnt_vld && (gnt_id == 1'b1);
    assign o_rsp_valid  = (state == ST_FULL);
    assign o_rsp_Y      = rsp_y;
    assign o_rsp_id     = rsp_id;

endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// Bench for barrel_shifter_arbiter: a round-robin and a fixed-priority
// instance share stimulus; directed tables, sequences and random traffic.
module tb_barrel_shifter_arbiter;

    logic       clk;
    logic       rstn;
    logic       v0, v1, rsp_ready;
    logic [7:0] a0, a1;
    logic [2:0] k0, k1;
    logic       rdy0 [2];
    logic       rdy1 [2];
    logic       rsp_v [2];
    logic [7:0] rsp_y [2];
    logic       rsp_id [2];

    int n_vec;
    int n_miss;

    barrel_shifter_arbiter #(.RR_EN(1'b1)) dut_rr (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0_valid(v0), .o_req0_ready(rdy0[0]),
        .i_req0_A(a0), .i_req0_k(k0),
        .i_req1_valid(v1), .o_req1_ready(rdy1[0]),
        .i_req1_A(a1), .i_req1_k(k1),
        .o_rsp_valid(rsp_v[0]), .i_rsp_ready(rsp_ready),
        .o_rsp_Y(rsp_y[0]), .o_rsp_id(rsp_id[0])
    );

    barrel_shifter_arbiter #(.RR_EN(1'b0)) dut_fp (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0_valid(v0), .o_req0_ready(rdy0[1]),
        .i_req0_A(a0), .i_req0_k(k0),
        .i_req1_valid(v1), .o_req1_ready(rdy1[1]),
        .i_req1_A(a1), .i_req1_k(k1),
        .o_rsp_valid(rsp_v[1]), .i_rsp_ready(rsp_ready),
        .o_rsp_Y(rsp_y[1]), .o_rsp_id(rsp_id[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] k;
        logic [7:0] y;
    } vec_t;

    vec_t tbl [9];

    // Reference model state per instance (0 = round-robin, 1 = fixed).
    bit       m_full [2];
    int       m_y    [2];
    int       m_id   [2];
    int       m_last [2];
    int       m_win  [2];

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    function automatic int rot(int a, int k);
        return ((a << k) | (a >> (8 - k))) & 255;
    endfunction

    function automatic int pick(int j);
        int w;
        w = -1;
        if (!m_full[j] || rsp_ready) begin
            if (v0 && v1)
                w = (j == 0) ? ((m_last[j] == 0) ? 1 : 0) : 0;
            else if (v0)
                w = 0;
            else if (v1)
                w = 1;
        end
        return w;
    endfunction

    initial begin
        n_vec = 0;
        n_miss = 0;
        rstn = 1'b0;
        rsp_ready = 1'b0;
        v0 = 1'b1; a0 = 8'h81; k0 = 3'd1;
        v1 = 1'b0; a1 = 8'h00; k1 = 3'd0;

        tbl[0] = '{8'h01, 3'd0, 8'h01};
        tbl[1] = '{8'h01, 3'd1, 8'h02};
        tbl[2] = '{8'h01, 3'd2, 8'h04};
        tbl[3] = '{8'h01, 3'd3, 8'h08};
        tbl[4] = '{8'h01, 3'd4, 8'h10};
        tbl[5] = '{8'h01, 3'd5, 8'h20};
        tbl[6] = '{8'h01, 3'd6, 8'h40};
        tbl[7] = '{8'h01, 3'd7, 8'h80};
        tbl[8] = '{8'hC3, 3'd0, 8'hC3};

        #3;
        chk("rst_rdy0", rdy0[0], 0);
        chk("rst_rdy0_fp", rdy0[1], 0);
        chk("rst_valid", rsp_v[0], 0);
        chk("rst_y", rsp_y[0], 8'h00);
        chk("rst_id", rsp_id[0], 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("single_rdy0", rdy0[0], 1);
        chk("single_rdy1", rdy1[0], 0);
        step();
        chk("single_valid", rsp_v[0], 1);
        chk("single_y", rsp_y[0], 8'h03);
        chk("single_id", rsp_id[0], 0);

        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a0 = tbl[i].a;
            k0 = tbl[i].k;
            @(negedge clk);
            chk("sweep_rdy", rdy0[0], 1);
            step();
            chk("sweep_y", rsp_y[0], tbl[i].y);
            chk("sweep_valid", rsp_v[0], 1);
        end
        v0 = 1'b0;

        do_reset();
        v0 = 1'b1; a0 = 8'hA5; k0 = 3'd4;
        v1 = 1'b1; a1 = 8'h01; k1 = 3'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_rdy0", rdy0[0], (i % 2 == 0) ? 1 : 0);
            chk("rr_rdy1", rdy1[0], (i % 2 == 1) ? 1 : 0);
            chk("fp_rdy0", rdy0[1], 1);
            chk("fp_rdy1", rdy1[1], 0);
            step();
            chk("rr_id", rsp_id[0], i % 2);
            chk("rr_y", rsp_y[0], (i % 2 == 1) ? 8'h80 : 8'h5A);
            chk("fp_id", rsp_id[1], 0);
            chk("fp_y", rsp_y[1], 8'h5A);
        end

        do_reset();
        v1 = 1'b0;
        v0 = 1'b1; a0 = 8'h3C; k0 = 3'd2;
        rsp_ready = 1'b0;
        step();
        v0 = 1'b0;
        v1 = 1'b1; a1 = 8'h96; k1 = 3'd3;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy0", rdy0[0], 0);
            chk("bp_rdy1", rdy1[0], 0);
            chk("bp_valid", rsp_v[0], 1);
            chk("bp_y", rsp_y[0], 8'hF0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy1", rdy1[0], 1);
        step();
        chk("bp_nogap_valid", rsp_v[0], 1);
        chk("bp_nogap_id", rsp_id[0], 1);
        chk("bp_nogap_y", rsp_y[0], 8'hB4);
        v1 = 1'b0;
        step();
        chk("drain_valid", rsp_v[0], 0);
        chk("drain_y_hold", rsp_y[0], 8'hB4);
        chk("drain_id_hold", rsp_id[0], 1);

        v0 = 1'b1; a0 = 8'h81; k0 = 3'd1;
        rsp_ready = 1'b0;
        step();
        v0 = 1'b0;
        @(negedge clk);
        chk("mid_full", rsp_v[0], 1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_v[0], 0);
        chk("mid_rst_y", rsp_y[0], 8'h00);
        #1;
        rstn = 1'b1;
        v0 = 1'b1; v1 = 1'b1;
        a0 = 8'h11; k0 = 3'd0; a1 = 8'h22; k1 = 3'd0;
        #1;
        chk("mid_tie_rdy0", rdy0[0], 1);
        chk("mid_tie_rdy1", rdy1[0], 0);
        step();
        chk("mid_tie_id", rsp_id[0], 0);

        do_reset();
        v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            m_full[j] = 1'b0;
            m_y[j] = 0;
            m_id[j] = 0;
            m_last[j] = 1;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                m_win[j] = pick(j);
                chk("rnd_rdy0", rdy0[j], (m_win[j] == 0) ? 1 : 0);
                chk("rnd_rdy1", rdy1[j], (m_win[j] == 1) ? 1 : 0);
                chk("rnd_valid", rsp_v[j], m_full[j]);
                chk("rnd_y", rsp_y[j], m_y[j]);
                chk("rnd_id", rsp_id[j], m_id[j]);
            end
            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                if (m_win[j] >= 0) begin
                    m_y[j] = (m_win[j] == 1) ? rot(a1, k1) : rot(a0, k0);
                    m_id[j] = m_win[j];
                    m_last[j] = m_win[j];
                    m_full[j] = 1'b1;
                end else if (m_full[j] && rsp_ready) begin
                    m_full[j] = 1'b0;
                end
            end
            #1;
            if (!v0 || m_win[0] == 0) begin
                v0 = ($urandom % 3) != 0;
                a0 = 8'($urandom);
                k0 = 3'($urandom);
            end
            if (!v1 || m_win[0] == 1) begin
                v1 = ($urandom % 3) != 0;
                a1 = 8'($urandom);
                k1 = 3'($urandom);
            end
            rsp_ready = ($urandom % 10) < 7;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
